// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame master.
// State encoding, error codes and the default ACK/NAK bytes.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DATA_HI = 3'd1,
      DATA_LO = 3'd2,
      CHECK   = 3'd3,
      ISSUE   = 3'd4,
      RESP    = 3'd5
   } state_e;

   typedef logic [1:0] err_code_t;

   localparam err_code_t ERR_NONE    = 2'b00;
   localparam err_code_t ERR_CHK     = 2'b01;
   localparam err_code_t ERR_TIMEOUT = 2'b10;
   localparam err_code_t ERR_OVERRUN = 2'b11;

   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

endpackage

// File: rtl/uart_cmd_master.sv
// Parses 4-byte UART command frames (header, data hi, data lo, xor checksum)
// into one-cycle register writes and answers each frame with ACK or NAK.
module uart_cmd_master
   import uart_cmd_pkg::*;
#(
   parameter int         AddrWidth     = 2,
   parameter int         TimeoutCycles = 1_000_000,
   parameter logic [3:0] SyncNibble    = 4'hA,
   parameter logic [7:0] AckByte       = ACK_BYTE,
   parameter logic [7:0] NakByte       = NAK_BYTE
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_dv_i,
   input  logic [7:0]           rx_data_i,
   input  logic                 tx_ready_i,
   output logic                 tx_valid_o,
   output logic [7:0]           tx_data_o,
   output logic                 dv_o,
   output logic [AddrWidth-1:0] addr_o,
   output logic [15:0]          data_o,
   output logic                 err_o,
   output logic [1:0]           err_code_o
);

   localparam int              CntW   = $clog2(TimeoutCycles);
   localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

   state_e               state_q;
   logic [AddrWidth-1:0] addr_q;
   logic [15:0]          data_q;
   logic [7:0]           chk_q;
   logic [CntW-1:0]      cnt_q;

   logic hdr_ok;
   logic in_frame;
   logic timeout;
   logic chk_bad;
   logic overrun;

   // Reserved header bits between the sync nibble and the address must be zero.
   assign hdr_ok   = (rx_data_i[7:4] == SyncNibble) &&
                     ((rx_data_i[3:0] >> AddrWidth) == 4'd0);
   assign in_frame = (state_q == DATA_HI) || (state_q == DATA_LO) ||
                     (state_q == CHECK);
   // A byte in the firing cycle wins over the timeout.
   assign timeout  = in_frame && !rx_dv_i && (cnt_q == CntMax);
   assign chk_bad  = (state_q == CHECK) && rx_dv_i && (rx_data_i != chk_q);
   assign overrun  = rx_dv_i && ((state_q == ISSUE) || (state_q == RESP));

   assign dv_o = (state_q == ISSUE);

   // Error sources live in disjoint states, so at most one fires per cycle.
   always_comb begin
      err_o      = 1'b0;
      err_code_o = ERR_NONE;
      if (chk_bad) begin
         err_o      = 1'b1;
         err_code_o = ERR_CHK;
      end else if (timeout) begin
         err_o      = 1'b1;
         err_code_o = ERR_TIMEOUT;
      end else if (overrun) begin
         err_o      = 1'b1;
         err_code_o = ERR_OVERRUN;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (!in_frame || rx_dv_i || timeout) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         chk_q      <= '0;
         addr_o     <= '0;
         data_o     <= '0;
         tx_valid_o <= 1'b0;
         tx_data_o  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rx_dv_i && hdr_ok) begin
                  addr_q  <= rx_data_i[AddrWidth-1:0];
                  chk_q   <= rx_data_i;
                  state_q <= DATA_HI;
               end
            end
            DATA_HI: begin
               if (rx_dv_i) begin
                  data_q[15:8] <= rx_data_i;
                  chk_q        <= chk_q ^ rx_data_i;
                  state_q      <= DATA_LO;
               end else if (timeout) begin
                  state_q <= IDLE;
               end
            end
            DATA_LO: begin
               if (rx_dv_i) begin
                  data_q[7:0] <= rx_data_i;
                  chk_q       <= chk_q ^ rx_data_i;
                  state_q     <= CHECK;
               end else if (timeout) begin
                  state_q <= IDLE;
               end
            end
            CHECK: begin
               if (rx_dv_i) begin
                  if (chk_bad) begin
                     tx_data_o  <= NakByte;
                     tx_valid_o <= 1'b1;
                     state_q    <= RESP;
                  end else begin
                     // Write-port outputs change only when a frame is accepted.
                     addr_o  <= addr_q;
                     data_o  <= data_q;
                     state_q <= ISSUE;
                  end
               end else if (timeout) begin
                  state_q <= IDLE;
               end
            end
            ISSUE: begin
               tx_data_o  <= AckByte;
               tx_valid_o <= 1'b1;
               state_q    <= RESP;
            end
            RESP: begin
               if (tx_ready_i) begin
                  tx_valid_o <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Scoreboard bench for uart_cmd_master: expected writes, responses and
// error codes are queued as frames are driven and popped as the DUT emits them.
module tb_uart_cmd_master;

   localparam int AW = 2;
   localparam int TO = 100;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          rx_dv_i;
   logic [7:0]    rx_data_i;
   logic          tx_ready_i;
   logic          tx_valid_o;
   logic [7:0]    tx_data_o;
   logic          dv_o;
   logic [AW-1:0] addr_o;
   logic [15:0]   data_o;
   logic          err_o;
   logic [1:0]    err_code_o;

   int errs   = 0;
   int checks = 0;

   logic [17:0] wq[$];
   logic [7:0]  tq[$];
   logic [1:0]  eq[$];

   uart_cmd_master #(
      .AddrWidth    (AW),
      .TimeoutCycles(TO),
      .SyncNibble   (4'hA),
      .AckByte      (8'h06),
      .NakByte      (8'h15)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .rx_dv_i   (rx_dv_i),
      .rx_data_i (rx_data_i),
      .tx_ready_i(tx_ready_i),
      .tx_valid_o(tx_valid_o),
      .tx_data_o (tx_data_o),
      .dv_o      (dv_o),
      .addr_o    (addr_o),
      .data_o    (data_o),
      .err_o     (err_o),
      .err_code_o(err_code_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_dv_i   = 1'b1;
      rx_data_i = b;
      @(posedge clk_i);
      #1;
      rx_dv_i   = 1'b0;
   endtask

   // Model: checksum is the xor of the first three bytes; ACK+write or NAK+err.
   task automatic frame(input logic [7:0] h, input logic [7:0] dh,
                        input logic [7:0] dl, input logic [7:0] ck);
      logic [7:0] c;
      logic       good;
      c    = h ^ dh ^ dl;
      good = (ck == c);
      if (good) begin
         wq.push_back({h[1:0], dh, dl});
         tq.push_back(8'h06);
      end else begin
         eq.push_back(2'b01);
         tq.push_back(8'h15);
      end
      send(h);
      send(dh);
      send(dl);
      send(ck);
      if (good) begin
         check("lat_dv", 32'(dv_o), 1);
         idle(1);
         check("lat_tx", 32'(tx_valid_o), 1);
      end else begin
         check("nak_nodv", 32'(dv_o), 0);
         check("nak_tx", 32'(tx_valid_o), 1);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (dv_o) begin
            if (wq.size() == 0) check("wr_unexp", 32'(dv_o), 0);
            else begin
               logic [17:0] w;
               w = wq.pop_front();
               check("wr_addr", 32'(addr_o), 32'(w[17:16]));
               check("wr_data", 32'(data_o), 32'(w[15:0]));
            end
         end
         if (tx_valid_o && tx_ready_i) begin
            if (tq.size() == 0) check("tx_unexp", 32'(tx_valid_o), 0);
            else check("tx_byte", 32'(tx_data_o), 32'(tq.pop_front()));
         end
         if (err_o) begin
            if (eq.size() == 0) check("err_unexp", 32'(err_o), 0);
            else check("err_code", 32'(err_code_o), 32'(eq.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      rst_ni     = 1'b0;
      rx_dv_i    = 1'b0;
      rx_data_i  = 8'h00;
      tx_ready_i = 1'b1;
      idle(3);
      check("rst_txv", 32'(tx_valid_o), 0);
      check("rst_txd", 32'(tx_data_o), 0);
      check("rst_dv", 32'(dv_o), 0);
      check("rst_addr", 32'(addr_o), 0);
      check("rst_data", 32'(data_o), 0);
      check("rst_err", 32'(err_o), 0);
      rst_ni = 1'b1;
      idle(2);

      // 1. accepted write
      frame(8'hA1, 8'h12, 8'h34, 8'h87);
      idle(2);

      // 2. bad checksum, then good frame
      frame(8'hA2, 8'h55, 8'hAA, 8'h00);
      idle(2);
      check("nak_addr_hold", 32'(addr_o), 1);
      check("nak_data_hold", 32'(data_o), 32'h1234);
      frame(8'hA3, 8'h00, 8'h01, 8'hA2);
      idle(2);

      // 3. header filtering
      send(8'h51);
      send(8'hA5);
      idle(2);
      frame(8'hA0, 8'hFF, 8'h00, 8'h5F);
      idle(2);

      // 4. timeout
      eq.push_back(2'b10);
      send(8'hA2);
      send(8'h12);
      cyc = 1;
      while (!err_o && cyc < 3 * TO) begin
         idle(1);
         cyc++;
      end
      check("to_cycles", 32'(cyc), TO);
      check("to_notx", 32'(tx_valid_o), 0);
      idle(2);
      frame(8'hA1, 8'hBE, 8'hEF, 8'hA1 ^ 8'hBE ^ 8'hEF);
      idle(2);

      // 5. backpressure and overrun
      tx_ready_i = 1'b0;
      frame(8'hA2, 8'h0F, 8'hF0, 8'h5D);
      for (int i = 0; i < 20; i++) begin
         check("bp_valid", 32'(tx_valid_o), 1);
         check("bp_data", 32'(tx_data_o), 32'h06);
         if (i == 5) begin
            eq.push_back(2'b11);
            send(8'h77);
         end else begin
            idle(1);
         end
      end
      tx_ready_i = 1'b1;
      idle(1);
      check("bp_fall", 32'(tx_valid_o), 0);
      idle(2);

      // 6. reset mid-frame
      send(8'hA1);
      send(8'h12);
      rst_ni = 1'b0;
      #1;
      check("mrst_addr", 32'(addr_o), 0);
      check("mrst_data", 32'(data_o), 0);
      check("mrst_txd", 32'(tx_data_o), 0);
      check("mrst_dv", 32'(dv_o), 0);
      check("mrst_err", 32'(err_o), 0);
      idle(3);
      rst_ni = 1'b1;
      send(8'h34);
      idle(2);
      check("mrst_ignored", 32'(data_o), 0);
      frame(8'hA1, 8'h12, 8'h34, 8'h87);
      idle(3);

      check("sb_wr_left", 32'(wq.size()), 0);
      check("sb_tx_left", 32'(tq.size()), 0);
      check("sb_err_left", 32'(eq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/uart_cmd_master.md
Name: uart_cmd_master

Overview:
Command-frame decoder sitting between a UART receive byte stream and the UART controller's register-write port. It parses 4-byte frames (header, data high, data low, checksum) and issues one-cycle register writes on dv_o/addr_o/data_o. It returns an ACK or NAK byte to the transmit path through a valid/ready handshake. This is the bus initiator for the controller's dv_i/addr_i/data_i responder port.

Parameters:
AddrWidth, 2, width of addr_o; legal range 1..4.
TimeoutCycles, 1_000_000, idle clocks allowed between bytes of one frame before the frame is aborted; minimum 2.
SyncNibble, 4'hA, required value of header bits [7:4].
AckByte, 8'h06, response byte for an accepted frame.
NakByte, 8'h15, response byte for a checksum failure.

Ports:
clk_i  in  1  single clock.
rst_ni  in  1  asynchronous, active-low reset.
rx_dv_i  in  1  one-cycle strobe; a received byte is valid.
rx_data_i  in  8  received byte.
tx_ready_i  in  1  transmit path accepts tx_data_o this cycle.
tx_valid_o  out  1  response byte valid.
tx_data_o  out  8  response byte (AckByte or NakByte).
dv_o  out  1  one-cycle register-write strobe.
addr_o  out  AddrWidth  write address.
data_o  out  16  write data.
err_o  out  1  one-cycle error strobe.
err_code_o  out  2  error cause, valid when err_o=1: 01 checksum, 10 timeout, 11 overrun.

Behaviour:
- Reset (rst_ni=0, asynchronous): state IDLE, all outputs 0, checksum and timeout counter 0.
- Checksum chk is the XOR of header, data-high and data-low bytes.
- IDLE: on rx_dv_i, the header is valid when rx_data_i[7:4]==SyncNibble and bits [3:AddrWidth] are all 0.
  - Valid header: latch addr = rx_data_i[AddrWidth-1:0], set chk = byte, go to DATA_HI.
  - Invalid header: silently discard the byte, stay in IDLE, no err_o pulse.
- DATA_HI: on a byte, latch data[15:8], chk ^= byte, go to DATA_LO.
- DATA_LO: on a byte, latch data[7:0], chk ^= byte, go to CHECK.
- CHECK: on a byte:
  - Byte == chk: go to ISSUE.
  - Byte != chk: pulse err_o with code 01, load NakByte, go to RESP. No write is issued.
- ISSUE: dv_o=1 for exactly one cycle with addr_o/data_o. Load AckByte, go to RESP.
- Latency: checksum byte strobed in cycle N gives dv_o=1 in cycle N+1 and tx_valid_o=1 from cycle N+2.
- addr_o and data_o hold their last written values between frames. They update only when a frame is accepted, at the cycle dv_o rises.
- RESP handshake:
  - tx_valid_o=1 with tx_data_o stable until tx_ready_i=1.
  - The transfer completes in the cycle both are high; the next cycle is IDLE with tx_valid_o=0.
  - If tx_ready_i is already high on the first RESP cycle, RESP lasts one cycle.
- Timeout:
  - In DATA_HI, DATA_LO and CHECK, the counter increments every cycle without rx_dv_i and clears on rx_dv_i.
  - When the counter reaches TimeoutCycles-1 without a byte: return to IDLE, pulse err_o with code 10, send no response, issue no write.
  - The counter is 0 in all other states.
  - A byte arriving in the same cycle the timeout would fire wins: it is consumed and the counter clears.
- Overrun: rx_dv_i during ISSUE or RESP drops the byte and pulses err_o with code 11 that cycle. The current response completes unchanged.
- Simultaneous errors cannot occur, because the error sources belong to disjoint states.
- Width rule: the timeout counter is $clog2(TimeoutCycles) bits wide.

Decomposition:
- Package uart_cmd_pkg holds:
  - the state enum: IDLE, DATA_HI, DATA_LO, CHECK, ISSUE, RESP;
  - the error-code typedef and its constants: ERR_CHK=2'b01, ERR_TIMEOUT=2'b10, ERR_OVERRUN=2'b11;
  - default ACK and NAK byte constants.
- Single module; no sub-module is needed. The timeout counter stays inline.

Test Plan:
1. Accepted write (bench TimeoutCycles=100): bytes A1, 12, 34, 87 -> one dv_o pulse with addr_o=1, data_o=0x1234 one cycle after the 87 strobe; tx_valid_o with tx_data_o=06; err_o never asserted.
2. Bad checksum: bytes A2, 55, AA, 00 -> err_o with code 01, tx_data_o=15 (NAK), no dv_o, addr_o/data_o unchanged. Then frame A3, 00, 01, A2 -> write addr=3, data=0x0001, ACK.
3. Header filtering with AddrWidth=2: bytes 51 and A5 (reserved bit set) are both ignored with no err_o. Then A0, FF, 00, 5F -> write addr=0, data=0xFF00.
4. Timeout: A2, 12, then silence -> exactly 100 clocks after the 12 strobe, err_o with code 10, state IDLE, no tx_valid_o. A following valid frame is accepted.
5. Response backpressure and overrun: accepted frame with tx_ready_i held low for 20 cycles -> tx_valid_o and tx_data_o=06 stable throughout. A byte 77 strobed during that window -> err_o with code 11 and no effect on the frame. Raise tx_ready_i -> tx_valid_o falls the next cycle.
6. Reset mid-frame: after A1, 12, assert rst_ni=0 for 3 cycles -> all outputs 0 immediately. After release, byte 34 is ignored and a full frame A1, 12, 34, 87 is accepted normally.
